// File: rtl/axi_llc_arcane_dma_ctl.sv
// LLC isolation lock plus a multi-channel DMA descriptor engine.
// The eCPU programs channels over a simple register port.
package axi_llc_arcane_dma_ctl_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

module axi_llc_arcane_dma_ctl #(
    parameter int unsigned NumChannels   = 2,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned BeatBytes     = 8,
    parameter int unsigned MaxBurstBeats = 16,
    parameter type reg_req_t = axi_llc_arcane_dma_ctl_pkg::reg_req_t,
    parameter type reg_rsp_t = axi_llc_arcane_dma_ctl_pkg::reg_rsp_t,
    localparam int unsigned ChanWidth =
        (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  reg_req_t             reg_req_i,
    output reg_rsp_t             reg_rsp_o,
    input  logic                 ecpu_lock_req_i,
    input  logic                 ecpu_lock_i,
    output logic                 lock_ready_o,
    output logic                 llc_isolate_o,
    input  logic                 llc_isolated_i,
    input  logic                 aw_unit_busy_i,
    input  logic                 ar_unit_busy_i,
    output logic [AddrWidth-1:0] r_desc_addr_o,
    output logic [7:0]           r_desc_len_o,
    output logic [ChanWidth-1:0] r_desc_chan_o,
    output logic                 r_desc_valid_o,
    input  logic                 r_desc_ready_i,
    output logic [AddrWidth-1:0] w_desc_addr_o,
    output logic [7:0]           w_desc_len_o,
    output logic [ChanWidth-1:0] w_desc_chan_o,
    output logic                 w_desc_valid_o,
    input  logic                 w_desc_ready_i,
    input  logic                 b_done_i,
    input  logic [ChanWidth-1:0] b_chan_i
);

    localparam int unsigned Off       = $clog2(BeatBytes);
    localparam logic [31:0] MapBytes  = 32'(NumChannels * 16);
    localparam logic [31:0] MaxBeats  = 32'(MaxBurstBeats);

    typedef enum logic [1:0] {IDLE, ISOLATE, LOCKED, UNLOCK} state_t;

    state_t state;
    logic   isolate;
    logic   granted;

    logic [AddrWidth-1:0] src     [NumChannels];
    logic [AddrWidth-1:0] dst     [NumChannels];
    logic [31:0]          len     [NumChannels];
    logic [31:0]          rd_left [NumChannels];
    logic [31:0]          wr_left [NumChannels];
    logic [31:0]          credit  [NumChannels];
    logic [31:0]          outst   [NumChannels];
    logic [NumChannels-1:0] busy;
    logic [NumChannels-1:0] done;
    logic [NumChannels-1:0] err;

    logic                 r_valid;
    logic [AddrWidth-1:0] r_addr;
    logic [7:0]           r_len;
    logic [ChanWidth-1:0] r_chan;
    logic [ChanWidth-1:0] r_ptr;
    logic                 w_valid;
    logic [AddrWidth-1:0] w_addr;
    logic [7:0]           w_len;
    logic [ChanWidth-1:0] w_chan;
    logic [ChanWidth-1:0] w_ptr;

    logic                   issue_en;
    logic [NumChannels-1:0] r_elig;
    logic [NumChannels-1:0] w_elig;
    logic [NumChannels-1:0] r_acc;
    logic [NumChannels-1:0] w_acc;
    logic [NumChannels-1:0] b_hit;
    logic [ChanWidth:0]     r_sel;
    logic [ChanWidth:0]     w_sel;
    logic [31:0]            r_beats;
    logic [31:0]            w_beats;

    logic [ChanWidth-1:0] sel_chan;
    logic [1:0]           sel_reg;
    logic                 in_range;
    logic                 we;
    logic                 busy_err;
    logic                 start;
    logic [AddrWidth-1:0] waddr;
    logic [31:0]          wlen;
    logic [31:0]          start_beats;

    // Returns {found, index}; search starts at ptr and wraps.
    function automatic logic [ChanWidth:0] rr_pick(
        input logic [NumChannels-1:0] elig,
        input logic [ChanWidth-1:0]   ptr
    );
        logic [ChanWidth:0]   res;
        logic [ChanWidth-1:0] idx;
        res = '0;
        for (int i = int'(NumChannels) - 1; i >= 0; i--) begin
            idx = ChanWidth'((int'(ptr) + i) % int'(NumChannels));
            if (elig[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [31:0] burst_of(input logic [31:0] left);
        return (left > MaxBeats) ? MaxBeats : left;
    endfunction

    function automatic logic [AddrWidth-1:0] step_of(input logic [7:0] l);
        return AddrWidth'((32'(l) + 32'd1) << Off);
    endfunction

    function automatic logic [ChanWidth-1:0] next_of(
        input logic [ChanWidth-1:0] c
    );
        return ChanWidth'((int'(c) + 1) % int'(NumChannels));
    endfunction

    assign issue_en = (state == LOCKED) || (state == UNLOCK);

    always_comb begin
        r_elig = '0;
        w_elig = '0;
        r_acc  = '0;
        w_acc  = '0;
        b_hit  = '0;
        for (int c = 0; c < int'(NumChannels); c++) begin
            r_elig[c] = busy[c] && (rd_left[c] != 32'd0);
            w_elig[c] = busy[c] && (credit[c] != 32'd0);
            r_acc[c]  = r_valid && r_desc_ready_i
                        && (r_chan == ChanWidth'(c));
            w_acc[c]  = w_valid && w_desc_ready_i
                        && (w_chan == ChanWidth'(c));
            b_hit[c]  = b_done_i && (b_chan_i == ChanWidth'(c))
                        && busy[c] && (outst[c] != 32'd0);
        end
    end

    assign r_sel   = rr_pick(r_elig, r_ptr);
    assign w_sel   = rr_pick(w_elig, w_ptr);
    assign r_beats = burst_of(rd_left[r_sel[ChanWidth-1:0]]);
    assign w_beats = burst_of(wr_left[w_sel[ChanWidth-1:0]]);

    assign sel_chan    = reg_req_i.addr[ChanWidth+3:4];
    assign sel_reg     = reg_req_i.addr[3:2];
    assign in_range    = reg_req_i.addr < MapBytes;
    assign we          = reg_req_i.valid && in_range && reg_req_i.write;
    assign busy_err    = we && (sel_reg != 2'd3) && busy[sel_chan];
    assign start       = we && (sel_reg == 2'd3) && reg_req_i.wdata[0]
                         && !busy[sel_chan];
    assign waddr       = AddrWidth'(reg_req_i.wdata)
                         & ~AddrWidth'(BeatBytes - 1);
    assign wlen        = reg_req_i.wdata & ~32'(BeatBytes - 1);
    assign start_beats = len[sel_chan] >> Off;

    always_comb begin
        reg_rsp_o = '0;
        if (rst_ni && reg_req_i.valid) begin
            reg_rsp_o.ready = 1'b1;
            reg_rsp_o.error = !in_range || busy_err;
            if (in_range && !reg_req_i.write) begin
                unique case (sel_reg)
                    2'd0: reg_rsp_o.rdata = 32'(src[sel_chan]);
                    2'd1: reg_rsp_o.rdata = 32'(dst[sel_chan]);
                    2'd2: reg_rsp_o.rdata = len[sel_chan];
                    2'd3: reg_rsp_o.rdata = {29'd0, err[sel_chan],
                                             done[sel_chan],
                                             busy[sel_chan]};
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            isolate <= 1'b0;
            granted <= 1'b0;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_chan  <= '0;
            r_ptr   <= '0;
            w_valid <= 1'b0;
            w_addr  <= '0;
            w_len   <= '0;
            w_chan  <= '0;
            w_ptr   <= '0;
            busy    <= '0;
            done    <= '0;
            err     <= '0;
            for (int c = 0; c < int'(NumChannels); c++) begin
                src[c]     <= '0;
                dst[c]     <= '0;
                len[c]     <= '0;
                rd_left[c] <= '0;
                wr_left[c] <= '0;
                credit[c]  <= '0;
                outst[c]   <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (ecpu_lock_req_i) begin
                        state   <= ISOLATE;
                        isolate <= 1'b1;
                    end
                end
                ISOLATE: begin
                    if (!ecpu_lock_req_i) begin
                        state   <= IDLE;
                        isolate <= 1'b0;
                    end else if (llc_isolated_i && !aw_unit_busy_i
                                 && !ar_unit_busy_i) begin
                        state   <= LOCKED;
                        granted <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (!ecpu_lock_i) begin
                        state   <= UNLOCK;
                        granted <= 1'b0;
                    end
                end
                UNLOCK: begin
                    if (busy == '0) begin
                        state   <= IDLE;
                        isolate <= 1'b0;
                    end
                end
            endcase

            // A presented descriptor is held until accepted, even when
            // the lock is lost; only new selections are gated.
            if (r_valid && r_desc_ready_i) begin
                r_valid <= 1'b0;
                r_ptr   <= next_of(r_chan);
            end else if (!r_valid && issue_en && r_sel[ChanWidth]) begin
                r_valid <= 1'b1;
                r_addr  <= src[r_sel[ChanWidth-1:0]];
                r_len   <= 8'(r_beats - 32'd1);
                r_chan  <= r_sel[ChanWidth-1:0];
            end

            if (w_valid && w_desc_ready_i) begin
                w_valid <= 1'b0;
                w_ptr   <= next_of(w_chan);
            end else if (!w_valid && issue_en && w_sel[ChanWidth]) begin
                w_valid <= 1'b1;
                w_addr  <= dst[w_sel[ChanWidth-1:0]];
                w_len   <= 8'(w_beats - 32'd1);
                w_chan  <= w_sel[ChanWidth-1:0];
            end

            for (int c = 0; c < int'(NumChannels); c++) begin
                if (r_acc[c]) begin
                    src[c]     <= src[c] + step_of(r_len);
                    rd_left[c] <= rd_left[c] - (32'(r_len) + 32'd1);
                end
                if (w_acc[c]) begin
                    dst[c]     <= dst[c] + step_of(w_len);
                    wr_left[c] <= wr_left[c] - (32'(w_len) + 32'd1);
                end
                credit[c] <= credit[c] + 32'(r_acc[c]) - 32'(w_acc[c]);
                outst[c]  <= outst[c] + 32'(w_acc[c]) - 32'(b_hit[c]);

                if (busy[c] && rd_left[c] == 32'd0
                    && wr_left[c] == 32'd0 && outst[c] == 32'd0) begin
                    busy[c] <= 1'b0;
                    done[c] <= 1'b1;
                end

                if (we && sel_chan == ChanWidth'(c) && !busy[c]) begin
                    unique case (sel_reg)
                        2'd0: src[c] <= waddr;
                        2'd1: dst[c] <= waddr;
                        2'd2: len[c] <= wlen;
                        2'd3: begin
                            if (start) begin
                                done[c] <= 1'b0;
                                err[c]  <= 1'b0;
                                if (state != LOCKED) begin
                                    err[c] <= 1'b1;
                                end else if (start_beats == 32'd0) begin
                                    done[c] <= 1'b1;
                                end else begin
                                    busy[c]    <= 1'b1;
                                    rd_left[c] <= start_beats;
                                    wr_left[c] <= start_beats;
                                    credit[c]  <= '0;
                                    outst[c]   <= '0;
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign lock_ready_o   = granted;
    assign llc_isolate_o  = isolate;
    assign r_desc_valid_o = r_valid;
    assign r_desc_addr_o  = r_addr;
    assign r_desc_len_o   = r_len;
    assign r_desc_chan_o  = r_chan;
    assign w_desc_valid_o = w_valid;
    assign w_desc_addr_o  = w_addr;
    assign w_desc_len_o   = w_len;
    assign w_desc_chan_o  = w_chan;

endmodule

// File: tb/tb_axi_llc_arcane_dma_ctl.sv
// Directed bench for axi_llc_arcane_dma_ctl: lock, bursting,
// arbitration, error paths, backpressure and reset.
module tb_axi_llc_arcane_dma_ctl;
    import axi_llc_arcane_dma_ctl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    reg_req_t    req;
    reg_rsp_t    rsp;
    logic        lock_req, lock_hold, lock_ready;
    logic        isolate, isolated, aw_busy, ar_busy;
    logic [31:0] r_addr, w_addr;
    logic [7:0]  r_len, w_len;
    logic        r_chan, w_chan;
    logic        r_valid, r_ready, w_valid, w_ready;
    logic        b_done, b_chan;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [31:0] rd;
    logic        e;
    logic [3:0]  chans;
    logic [127:0] addrs;
    int          n;

    always #5 clk = ~clk;

    axi_llc_arcane_dma_ctl #(
        .NumChannels  (2),
        .AddrWidth    (32),
        .BeatBytes    (8),
        .MaxBurstBeats(16)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .reg_req_i      (req),
        .reg_rsp_o      (rsp),
        .ecpu_lock_req_i(lock_req),
        .ecpu_lock_i    (lock_hold),
        .lock_ready_o   (lock_ready),
        .llc_isolate_o  (isolate),
        .llc_isolated_i (isolated),
        .aw_unit_busy_i (aw_busy),
        .ar_unit_busy_i (ar_busy),
        .r_desc_addr_o  (r_addr),
        .r_desc_len_o   (r_len),
        .r_desc_chan_o  (r_chan),
        .r_desc_valid_o (r_valid),
        .r_desc_ready_i (r_ready),
        .w_desc_addr_o  (w_addr),
        .w_desc_len_o   (w_len),
        .w_desc_chan_o  (w_chan),
        .w_desc_valid_o (w_valid),
        .w_desc_ready_i (w_ready),
        .b_done_i       (b_done),
        .b_chan_i       (b_chan)
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [31:0] a, input logic [31:0] d,
                          output logic er);
        req.addr  = a;
        req.wdata = d;
        req.write = 1'b1;
        req.valid = 1'b1;
        #1;
        er = rsp.error;
        tick();
        req.valid = 1'b0;
        req.write = 1'b0;
    endtask

    task automatic reg_rd(input logic [31:0] a, output logic [31:0] d,
                          output logic er);
        req.addr  = a;
        req.write = 1'b0;
        req.valid = 1'b1;
        #1;
        d  = rsp.rdata;
        er = rsp.error;
        req.valid = 1'b0;
    endtask

    task automatic wait_r(input string tag);
        int k = 0;
        while (!r_valid && k < 50) begin
            tick();
            k++;
        end
        check(tag, 128'(r_valid), 128'd1);
    endtask

    task automatic wait_w(input string tag);
        int k = 0;
        while (!w_valid && k < 50) begin
            tick();
            k++;
        end
        check(tag, 128'(w_valid), 128'd1);
    endtask

    task automatic b_pulse(input logic c);
        b_done = 1'b1;
        b_chan = c;
        tick();
        b_done = 1'b0;
    endtask

    initial begin
        req       = '0;
        rst_n     = 1'b0;
        lock_req  = 1'b0;
        lock_hold = 1'b0;
        isolated  = 1'b0;
        aw_busy   = 1'b0;
        ar_busy   = 1'b0;
        r_ready   = 1'b0;
        w_ready   = 1'b0;
        b_done    = 1'b0;
        b_chan    = 1'b0;
        tick();
        tick();
        check("reset_outputs",
              {lock_ready, isolate, r_valid, w_valid, r_addr, r_len,
               w_addr, w_len, r_chan, w_chan},
              128'd0);
        rst_n = 1'b1;
        tick();

        // start while unlocked
        reg_wr(32'h08, 32'h40, e);
        reg_wr(32'h0C, 32'h1, e);
        reg_rd(32'h0C, rd, e);
        check("start_unlocked_ctrl", 128'(rd), 128'h4);
        reg_rd(32'h20, rd, e);
        check("oob_read", {e, rd}, {1'b1, 32'h0});
        reg_wr(32'h20, 32'h5, e);
        check("oob_write_err", 128'(e), 128'd1);

        // lock handshake
        lock_req  = 1'b1;
        lock_hold = 1'b1;
        ar_busy   = 1'b1;
        tick();
        check("isolate_entry", {isolate, lock_ready}, 128'b10);
        tick();
        tick();
        isolated = 1'b1;
        tick();
        tick();
        check("held_by_ar_busy", 128'(lock_ready), 128'd0);
        ar_busy = 1'b0;
        #1;
        check("grant_not_early", 128'(lock_ready), 128'd0);
        tick();
        check("grant_next_cycle", {isolate, lock_ready}, 128'b11);

        // 40-beat transfer on channel 0
        reg_wr(32'h00, 32'h1000, e);
        reg_wr(32'h04, 32'h8000, e);
        reg_wr(32'h08, 32'h140, e);
        reg_wr(32'h0C, 32'h1, e);
        wait_r("r0_timeout");
        check("r0_desc", {r_chan, r_len, r_addr}, {1'b0, 8'd15, 32'h1000});
        reg_wr(32'h00, 32'hDEAD0, e);
        check("src_busy_err", 128'(e), 128'd1);
        reg_rd(32'h00, rd, e);
        check("src_unchanged", 128'(rd), 128'h1000);
        for (int i = 0; i < 9; i++) tick();
        check("backpressure_stable", {r_valid, r_chan, r_len, r_addr},
              {1'b1, 1'b0, 8'd15, 32'h1000});
        check("no_write_before_read", 128'(w_valid), 128'd0);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        wait_r("r1_timeout");
        check("r1_desc", {r_len, r_addr}, {8'd15, 32'h1080});
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        wait_r("r2_timeout");
        check("r2_desc", {r_len, r_addr}, {8'd7, 32'h1100});
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        wait_w("w0_timeout");
        check("w0_desc", {w_chan, w_len, w_addr}, {1'b0, 8'd15, 32'h8000});
        w_ready = 1'b1;
        tick();
        w_ready = 1'b0;
        wait_w("w1_timeout");
        check("w1_desc", {w_len, w_addr}, {8'd15, 32'h8080});
        w_ready = 1'b1;
        tick();
        w_ready = 1'b0;
        wait_w("w2_timeout");
        check("w2_desc", {w_len, w_addr}, {8'd7, 32'h8100});
        w_ready = 1'b1;
        tick();
        w_ready = 1'b0;
        tick();
        check("no_extra_r", {r_valid, w_valid}, 128'd0);
        reg_rd(32'h0C, rd, e);
        check("busy_before_b", 128'(rd), 128'h1);
        b_pulse(1'b0);
        b_pulse(1'b0);
        tick();
        reg_rd(32'h0C, rd, e);
        check("busy_after_2b", 128'(rd), 128'h1);
        b_pulse(1'b0);
        tick();
        reg_rd(32'h0C, rd, e);
        check("done_after_3b", 128'(rd), 128'h2);

        // zero length on channel 1
        reg_wr(32'h18, 32'h7, e);
        reg_wr(32'h1C, 32'h1, e);
        reg_rd(32'h1C, rd, e);
        check("zero_len_done", 128'(rd), 128'h2);
        check("zero_len_no_desc", 128'(r_valid), 128'd0);

        // round-robin between channels 0 and 1
        reg_wr(32'h00, 32'h2000, e);
        reg_wr(32'h08, 32'h100, e);
        reg_wr(32'h0C, 32'h1, e);
        reg_wr(32'h10, 32'h3000, e);
        reg_wr(32'h18, 32'h100, e);
        reg_wr(32'h1C, 32'h1, e);
        r_ready = 1'b1;
        w_ready = 1'b1;
        chans = '0;
        addrs = '0;
        n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            if (r_valid) begin
                chans = {chans[2:0], r_chan};
                addrs = {addrs[95:0], r_addr};
                n++;
            end
            tick();
        end
        check("rr_count", 128'(n), 128'd4);
        check("rr_chan_seq", 128'(chans), 128'b0101);
        check("rr_addr_seq", addrs,
              {32'h2000, 32'h3000, 32'h2080, 32'h3080});
        for (int i = 0; i < 20; i++) tick();
        r_ready = 1'b0;
        w_ready = 1'b0;
        b_pulse(1'b0);
        b_pulse(1'b1);
        b_pulse(1'b0);
        b_pulse(1'b1);
        tick();
        reg_rd(32'h0C, rd, e);
        check("rr_ch0_done", 128'(rd), 128'h2);
        reg_rd(32'h1C, rd, e);
        check("rr_ch1_done", 128'(rd), 128'h2);
        b_pulse(1'b1);
        tick();
        reg_rd(32'h1C, rd, e);
        check("idle_b_ignored", 128'(rd), 128'h2);

        // release the lock
        lock_req  = 1'b0;
        lock_hold = 1'b0;
        tick();
        check("unlock_state", {isolate, lock_ready}, 128'b10);
        tick();
        check("back_to_idle", {isolate, lock_ready}, 128'b00);

        // reset mid-transfer
        lock_req  = 1'b1;
        lock_hold = 1'b1;
        tick();
        tick();
        check("relock", 128'(lock_ready), 128'd1);
        reg_wr(32'h00, 32'h1000, e);
        reg_wr(32'h08, 32'h140, e);
        reg_wr(32'h0C, 32'h1, e);
        wait_r("rst_r_timeout");
        rst_n = 1'b0;
        #1;
        check("reset_mid_outputs",
              {lock_ready, isolate, r_valid, w_valid, r_addr, r_len,
               w_addr, w_len, r_chan, w_chan},
              128'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("no_desc_after_reset", {r_valid, w_valid}, 128'd0);
        reg_rd(32'h0C, rd, e);
        check("ctrl_after_reset", 128'(rd), 128'h0);
        reg_rd(32'h00, rd, e);
        check("src_after_reset", 128'(rd), 128'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
